// File: rtl/audio_sample_scheduler.sv
// Per-sample-period arbiter for the shared song ROM: picks crash > jump > song,
// fetches one word and pushes it left-justified into the audio output FIFO.
module audio_sample_scheduler #(
    parameter int SAMPLE_DIV = 12500,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 14,
    parameter int SONG_BASE  = 0,
    parameter int SONG_LEN   = 40000,
    parameter int JUMP_BASE  = 40000,
    parameter int JUMP_LEN   = 2000,
    parameter int CRASH_BASE = 42000,
    parameter int CRASH_LEN  = 4000
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              song_en,
    input  logic              song_restart,
    input  logic              trig_jump,
    input  logic              trig_crash,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rden,
    input  logic [DATA_W-1:0] rom_q,
    input  logic              audio_out_allowed,
    output logic              write_audio_out,
    output logic [31:0]       sample_out,
    output logic [1:0]        active_src,
    output logic              overrun
);

    localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD    = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [ADDR_W-1:0] SONG_START  = ADDR_W'(SONG_BASE);
    localparam logic [ADDR_W-1:0] SONG_END    = ADDR_W'(SONG_BASE + SONG_LEN - 1);
    localparam logic [ADDR_W-1:0] JUMP_START  = ADDR_W'(JUMP_BASE);
    localparam logic [ADDR_W-1:0] JUMP_END    = ADDR_W'(JUMP_BASE + JUMP_LEN - 1);
    localparam logic [ADDR_W-1:0] CRASH_START = ADDR_W'(CRASH_BASE);
    localparam logic [ADDR_W-1:0] CRASH_END   = ADDR_W'(CRASH_BASE + CRASH_LEN - 1);

    localparam logic [1:0] SRC_NONE  = 2'd0;
    localparam logic [1:0] SRC_SONG  = 2'd1;
    localparam logic [1:0] SRC_JUMP  = 2'd2;
    localparam logic [1:0] SRC_CRASH = 2'd3;

    typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, PUSH} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic              tick;
    logic [ADDR_W-1:0] song_ptr_reg, song_ptr_next;
    logic [ADDR_W-1:0] jump_ptr_reg, jump_ptr_next;
    logic [ADDR_W-1:0] crash_ptr_reg, crash_ptr_next;
    logic              jump_act_reg, jump_act_next;
    logic              crash_act_reg, crash_act_next;
    logic [2:0]        req_pend_reg, req_pend_next;
    logic [2:0]        req_now;
    logic [ADDR_W-1:0] rom_addr_reg, rom_addr_next;
    logic              rom_rden_reg, rom_rden_next;
    logic [31:0]       sample_reg, sample_next;
    logic [1:0]        src_reg, src_next;
    logic [1:0]        sel;
    logic              overrun_reg, overrun_next;

    assign tick = (cnt_reg == '0);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)
            cnt_reg <= CNT_LOAD;
        else if (tick)
            cnt_reg <= CNT_LOAD;
        else
            cnt_reg <= cnt_reg - CNT_W'(1);
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= IDLE;
            song_ptr_reg  <= SONG_START;
            jump_ptr_reg  <= JUMP_START;
            crash_ptr_reg <= CRASH_START;
            jump_act_reg  <= 1'b0;
            crash_act_reg <= 1'b0;
            req_pend_reg  <= '0;
            rom_addr_reg  <= '0;
            rom_rden_reg  <= 1'b0;
            sample_reg    <= '0;
            src_reg       <= SRC_NONE;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            song_ptr_reg  <= song_ptr_next;
            jump_ptr_reg  <= jump_ptr_next;
            crash_ptr_reg <= crash_ptr_next;
            jump_act_reg  <= jump_act_next;
            crash_act_reg <= crash_act_next;
            req_pend_reg  <= req_pend_next;
            rom_addr_reg  <= rom_addr_next;
            rom_rden_reg  <= rom_rden_next;
            sample_reg    <= sample_next;
            src_reg       <= src_next;
            overrun_reg   <= overrun_next;
        end
    end

    // Requests are {crash, jump, restart}; they are held until the FSM is back in
    // IDLE so a trigger landing on CAPTURE of the same source still restarts it.
    assign req_now = req_pend_reg | {trig_crash, trig_jump, song_restart};

    always_comb begin
        state_next     = state_reg;
        song_ptr_next  = song_ptr_reg;
        jump_ptr_next  = jump_ptr_reg;
        crash_ptr_next = crash_ptr_reg;
        jump_act_next  = jump_act_reg;
        crash_act_next = crash_act_reg;
        req_pend_next  = req_now;
        rom_addr_next  = rom_addr_reg;
        rom_rden_next  = 1'b0;
        sample_next    = sample_reg;
        src_next       = src_reg;
        sel            = SRC_NONE;
        overrun_next   = overrun_reg | (tick && (state_reg != IDLE));

        case (state_reg)
            IDLE: begin
                req_pend_next = '0;
                if (req_now[0])
                    song_ptr_next = SONG_START;
                if (req_now[1]) begin
                    jump_ptr_next = JUMP_START;
                    jump_act_next = 1'b1;
                end
                if (req_now[2]) begin
                    crash_ptr_next = CRASH_START;
                    crash_act_next = 1'b1;
                end
                if (tick) begin
                    if (crash_act_next)
                        sel = SRC_CRASH;
                    else if (jump_act_next)
                        sel = SRC_JUMP;
                    else if (song_en)
                        sel = SRC_SONG;
                    src_next = sel;
                    case (sel)
                        SRC_CRASH: rom_addr_next = crash_ptr_next;
                        SRC_JUMP:  rom_addr_next = jump_ptr_next;
                        SRC_SONG:  rom_addr_next = song_ptr_next;
                        default:   rom_addr_next = rom_addr_reg;
                    endcase
                    if (sel == SRC_NONE) begin
                        sample_next = '0;
                        state_next  = PUSH;
                    end else begin
                        rom_rden_next = 1'b1;
                        state_next    = FETCH;
                    end
                end
            end
            FETCH: state_next = CAPTURE;
            CAPTURE: begin
                sample_next = {rom_q, {(32-DATA_W){1'b0}}};
                case (src_reg)
                    SRC_SONG:
                        song_ptr_next = (song_ptr_reg == SONG_END) ? SONG_START
                                                                   : song_ptr_reg + ADDR_W'(1);
                    SRC_JUMP:
                        if (jump_ptr_reg == JUMP_END) begin
                            jump_act_next = 1'b0;
                            jump_ptr_next = JUMP_START;
                        end else begin
                            jump_ptr_next = jump_ptr_reg + ADDR_W'(1);
                        end
                    SRC_CRASH:
                        if (crash_ptr_reg == CRASH_END) begin
                            crash_act_next = 1'b0;
                            crash_ptr_next = CRASH_START;
                        end else begin
                            crash_ptr_next = crash_ptr_reg + ADDR_W'(1);
                        end
                    default: ;
                endcase
                state_next = PUSH;
            end
            PUSH: begin
                if (audio_out_allowed)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign rom_addr        = rom_addr_reg;
    assign rom_rden        = rom_rden_reg;
    assign write_audio_out = (state_reg == PUSH);
    assign sample_out      = sample_reg;
    assign active_src      = src_reg;
    assign overrun         = overrun_reg;

endmodule
